// File: rtl/mod_counter_pkg.sv
//------------------------------------------------------------------------------
// mod_counter_pkg
// Shared constants and per-cycle operation selection for mod_counter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mod_counter_pkg;

  `include "mod_counter_defs.vh"

  // Operation applied to the counter in one cycle.
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_STEP  = 2'd1,
    OP_LOAD  = 2'd2,
    OP_CLEAR = 2'd3
  } op_e;

  // Resolve the control inputs with clear > load > enable > hold priority.
  function automatic op_e sel_op(input logic clr, input logic ld, input logic en);
    if (clr) begin
      return OP_CLEAR;
    end else if (ld) begin
      return OP_LOAD;
    end else if (en) begin
      return OP_STEP;
    end
    return OP_HOLD;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod_counter_defs.vh
//------------------------------------------------------------------------------
// mod_counter_defs.vh
// Shared encoding constants for the mod_counter direction and terminal mode.
// Revision: 1.0
//------------------------------------------------------------------------------
`ifndef MOD_COUNTER_DEFS_VH
`define MOD_COUNTER_DEFS_VH

localparam logic DIR_UP    = 1'b1;
localparam logic DIR_DOWN  = 1'b0;
localparam logic MODE_WRAP = 1'b1;
localparam logic MODE_SAT  = 1'b0;

`endif

// File: rtl/mod_counter_step.sv
//------------------------------------------------------------------------------
// mod_counter_step
// Combinational step logic: next count, terminal event and saturate-hold for
// one enabled step from the current count, limit, direction and mode.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mod_counter_step
  import mod_counter_pkg::*;
#(
  parameter int WIDTH = 25
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic             up_down_i,
  input  logic             wrap_i,
  output logic [WIDTH-1:0] next_o,
  output logic             term_o,
  output logic             sat_hold_o
);

  // Next value for a step; a count above limit counts as being at the up terminal.
  always_comb begin
    next_o = count_i;
    term_o = 1'b0;
    if (up_down_i == DIR_UP) begin
      if (count_i >= limit_i) begin
        term_o = 1'b1;
        next_o = (wrap_i == MODE_WRAP) ? '0 : limit_i;
      end else begin
        next_o = count_i + WIDTH'(1);
      end
    end else begin
      if (count_i == '0) begin
        term_o = 1'b1;
        next_o = (wrap_i == MODE_WRAP) ? limit_i : '0;
      end else begin
        next_o = count_i - WIDTH'(1);
      end
    end
  end

  assign sat_hold_o = term_o & (wrap_i == MODE_SAT);

endmodule

`default_nettype wire

// File: rtl/mod_counter.sv
//------------------------------------------------------------------------------
// mod_counter
// Up/down counter with programmable upper limit, wrap or saturate at the
// terminal, terminal-count pulse, saturated level and sticky overflow flag.
// Optional feature macro: MOD_COUNTER_CAPTURE_EN adds capture/captured ports
// that snapshot the current count on request.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH     = 25,
  parameter int RESET_VAL = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up_down,
  input  logic [WIDTH-1:0] limit,
  input  logic             wrap,
`ifdef MOD_COUNTER_CAPTURE_EN
  input  logic             capture,
  output logic [WIDTH-1:0] captured,
`endif
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             saturated,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             sat_q, sat_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] step_next;
  logic             step_term;
  logic             step_sat_hold;

  mod_counter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .count_i    (count_q),
    .limit_i    (limit),
    .up_down_i  (up_down),
    .wrap_i     (wrap),
    .next_o     (step_next),
    .term_o     (step_term),
    .sat_hold_o (step_sat_hold)
  );

  // Next state: tc is a single-cycle pulse, saturated and overflow are levels.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    sat_d   = sat_q;
    ovf_d   = ovf_q;
    case (sel_op(clear, load, enable))
      OP_CLEAR: begin
        count_d = RST_COUNT;
        sat_d   = 1'b0;
        ovf_d   = 1'b0;
      end
      OP_LOAD: begin
        count_d = load_value;
        sat_d   = 1'b0;
      end
      OP_STEP: begin
        count_d = step_next;
        tc_d    = step_term & (wrap == MODE_WRAP);
        sat_d   = step_sat_hold;
        ovf_d   = ovf_q | step_term;
      end
      default: begin
      end
    endcase
  end

  // Counter state registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= RST_COUNT;
      tc_q    <= 1'b0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef MOD_COUNTER_CAPTURE_EN
  logic [WIDTH-1:0] captured_q;

  // Snapshot of the current count, independent of clear/load/enable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      captured_q <= '0;
    end else if (capture) begin
      captured_q <= count_q;
    end
  end

  assign captured = captured_q;
`else
  // Capture feature not built: no capture register exists.
`endif

  assign count_out = count_q;
  assign tc        = tc_q;
  assign saturated = sat_q;
  assign overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_mod_counter.sv
//------------------------------------------------------------------------------
// tb_mod_counter
// Self-checking bench for mod_counter with directed scenarios and randomized
// traffic compared against a behavioural reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mod_counter;

  localparam int WIDTH = 4;
  localparam int RV    = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic             enable;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             up_down;
  logic [WIDTH-1:0] limit;
  logic             wrap;
  logic [WIDTH-1:0] count_out;
  logic             tc;
  logic             saturated;
  logic             overflow;
`ifdef MOD_COUNTER_CAPTURE_EN
  logic             capture;
  logic [WIDTH-1:0] captured;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_cnt;
  bit m_tc;
  bit m_sat;
  bit m_ovf;
  int m_cap;

  mod_counter #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RV)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .up_down    (up_down),
    .limit      (limit),
    .wrap       (wrap),
`ifdef MOD_COUNTER_CAPTURE_EN
    .capture    (capture),
    .captured   (captured),
`endif
    .count_out  (count_out),
    .tc         (tc),
    .saturated  (saturated),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = RV;
    m_tc  = 0;
    m_sat = 0;
    m_ovf = 0;
    m_cap = 0;
  endtask

  // One clock of the specified behaviour, using the inputs present at the edge.
  task automatic model_step();
    bit at_term;
`ifdef MOD_COUNTER_CAPTURE_EN
    if (capture) m_cap = m_cnt;
`endif
    if (clear) begin
      m_cnt = RV; m_tc = 0; m_sat = 0; m_ovf = 0;
    end else if (load) begin
      m_cnt = int'(load_value); m_tc = 0; m_sat = 0;
    end else if (enable) begin
      at_term = up_down ? (m_cnt >= int'(limit)) : (m_cnt == 0);
      if (at_term) begin
        m_ovf = 1;
        if (wrap) begin
          m_cnt = up_down ? 0 : int'(limit);
          m_tc  = 1; m_sat = 0;
        end else begin
          m_cnt = up_down ? int'(limit) : 0;
          m_tc  = 0; m_sat = 1;
        end
      end else begin
        m_cnt = up_down ? m_cnt + 1 : m_cnt - 1;
        m_tc  = 0; m_sat = 0;
      end
    end else begin
      m_tc = 0;
    end
  endtask

  task automatic check_model();
    check("count", count_out, m_cnt);
    check("tc", tc, m_tc);
    check("saturated", saturated, m_sat);
    check("overflow", overflow, m_ovf);
`ifdef MOD_COUNTER_CAPTURE_EN
    check("captured", captured, m_cap);
`endif
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check_model();
  endtask

  task automatic do_load(input int v);
    load = 1; load_value = WIDTH'(v); enable = 0;
    tick();
    load = 0;
  endtask

  initial begin
    reset = 1; enable = 0; clear = 0; load = 0; load_value = '0;
    up_down = 1; limit = 4'd5; wrap = 1;
`ifdef MOD_COUNTER_CAPTURE_EN
    capture = 0;
`endif
    model_reset();
    #12;
    check("rst_count", count_out, RV);
    check("rst_tc", tc, 0);
    check("rst_sat", saturated, 0);
    check("rst_ovf", overflow, 0);
    reset = 0;

    // Wrap-up sequence 0..5,0 at limit 5
    do_load(0);
    limit = 4'd5; wrap = 1; up_down = 1; enable = 1;
    repeat (6) tick();
    check("w_up_count", count_out, 0);
    check("w_up_tc", tc, 1);
    check("w_up_ovf", overflow, 1);
    tick();
    check("w_up_tc_drop", tc, 0);
    check("w_up_ovf_stick", overflow, 1);

    // Saturate-up from 4 at limit 5, then reverse
    do_load(4);
    wrap = 0; enable = 1;
    tick();
    check("sat_first", count_out, 5);
    check("sat_first_flag", saturated, 0);
    tick();
    check("sat_hold", count_out, 5);
    check("sat_hold_flag", saturated, 1);
    tick();
    check("sat_hold_tc", tc, 0);
    up_down = 0;
    tick();
    check("sat_rev_count", count_out, 4);
    check("sat_rev_flag", saturated, 0);

    // Wrap-down at limit 9, then load beats enable
    do_load(1);
    limit = 4'd9; wrap = 1; up_down = 0; enable = 1;
    tick();
    check("w_dn_zero", count_out, 0);
    tick();
    check("w_dn_wrap", count_out, 9);
    check("w_dn_tc", tc, 1);
    load = 1; load_value = 4'd12; enable = 1;
    tick();
    check("load_over_en", count_out, 12);
    check("load_tc_low", tc, 0);
    load = 0;

    // Count above limit counting up
    up_down = 1; wrap = 1; enable = 1;
    tick();
    check("above_wrap", count_out, 0);
    check("above_wrap_tc", tc, 1);
    do_load(12);
    wrap = 0; enable = 1;
    tick();
    check("above_sat", count_out, 9);
    check("above_sat_flag", saturated, 1);

    // Clear beats load
    do_load(7);
    clear = 1; load = 1; load_value = 4'd11;
    tick();
    check("clr_load", count_out, RV);
    check("clr_ovf", overflow, 0);
    clear = 0; load = 0;

    // Asynchronous reset between edges
    do_load(5);
    enable = 1; up_down = 1; wrap = 0; limit = 4'd9;
    tick();
    #2 reset = 1;
    #1;
    model_reset();
    check("arst_count", count_out, RV);
    check("arst_tc", tc, 0);
    check("arst_sat", saturated, 0);
    check("arst_ovf", overflow, 0);
    #1 reset = 0;
    tick();
    check("arst_resume", count_out, RV + 1);

`ifdef MOD_COUNTER_CAPTURE_EN
    do_load(3);
    capture = 1; clear = 1;
    tick();
    check("cap_value", captured, 3);
    check("cap_count", count_out, RV);
    capture = 0; clear = 0;
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      clear      = ($urandom_range(15) == 0);
      load       = ($urandom_range(7) == 0);
      enable     = ($urandom_range(3) != 0);
      up_down    = 1'($urandom_range(1));
      wrap       = 1'($urandom_range(1));
      limit      = WIDTH'($urandom_range(15));
      load_value = WIDTH'($urandom_range(15));
`ifdef MOD_COUNTER_CAPTURE_EN
      capture    = ($urandom_range(3) == 0);
`endif
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
